// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel coordinates, visibility qualifier, sync pulses,
// frame-start strobe and a completed-frame counter. Every output is a register
// loaded from next-state values, so all outputs describe the coordinate that
// is presented in the same cycle.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned CW      = 10;
  localparam int unsigned FW      = 8;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Last counter value of each phase; the phase FSMs advance when it is reached.
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] H_FRT_END  = CW'(H_ACTIVE + H_FRONT - 1);
  localparam logic [CW-1:0] H_SYN_END  = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] V_FRT_END  = CW'(V_ACTIVE + V_FRONT - 1);
  localparam logic [CW-1:0] V_SYN_END  = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic          run;
  phase_t        h_ph;
  phase_t        v_ph;

  logic [CW-1:0] hc_nxt;
  logic [CW-1:0] vc_nxt;
  logic [FW-1:0] fc_nxt;
  phase_t        h_ph_nxt;
  phase_t        v_ph_nxt;
  logic          h_wrap;
  logic          v_wrap;

  assign DrawX = hc;
  assign DrawY = vc;

  // Next counter values and phase transitions; everything holds until run is set.
  always_comb begin
    hc_nxt   = hc;
    vc_nxt   = vc;
    fc_nxt   = frame_count;
    h_ph_nxt = h_ph;
    v_ph_nxt = v_ph;
    h_wrap   = (hc == H_LAST);
    v_wrap   = (vc == V_LAST);
    if (run) begin
      hc_nxt = h_wrap ? '0 : hc + CW'(1);
      if (h_wrap) begin
        vc_nxt = v_wrap ? '0 : vc + CW'(1);
        if (v_wrap) begin
          fc_nxt = frame_count + FW'(1);
        end
      end
      case (h_ph)
        PH_ACTIVE: if (hc == H_ACT_END) h_ph_nxt = PH_FRONT;
        PH_FRONT:  if (hc == H_FRT_END) h_ph_nxt = PH_SYNC;
        PH_SYNC:   if (hc == H_SYN_END) h_ph_nxt = PH_BACK;
        PH_BACK:   if (h_wrap)          h_ph_nxt = PH_ACTIVE;
      endcase
      if (h_wrap) begin
        case (v_ph)
          PH_ACTIVE: if (vc == V_ACT_END) v_ph_nxt = PH_FRONT;
          PH_FRONT:  if (vc == V_FRT_END) v_ph_nxt = PH_SYNC;
          PH_SYNC:   if (vc == V_SYN_END) v_ph_nxt = PH_BACK;
          PH_BACK:   if (v_wrap)          v_ph_nxt = PH_ACTIVE;
        endcase
      end
    end
  end

  // State and output registers; reset has priority over every wrap and increment.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc          <= '0;
      vc          <= '0;
      run         <= 1'b0;
      h_ph        <= PH_ACTIVE;
      v_ph        <= PH_ACTIVE;
      blank       <= 1'b0;
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      run         <= 1'b1;
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      h_ph        <= h_ph_nxt;
      v_ph        <= v_ph_nxt;
      frame_count <= fc_nxt;
      blank       <= (h_ph_nxt == PH_ACTIVE) && (v_ph_nxt == PH_ACTIVE);
      hs          <= (h_ph_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vs          <= (v_ph_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-geometry instance for whole-frame and
// frame-counter wrap coverage, and a 640x480 instance for line-level timing.
// Both are compared every cycle against a raster-position model.
module tb_vga_timing_gen;

  localparam int SH_A = 12, SH_F = 2, SH_S = 3, SH_B = 3;
  localparam int SV_A = 5,  SV_F = 1, SV_S = 2, SV_B = 2;
  localparam int FR_S = (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B);
  localparam int FR_D = 800 * 525;

  logic       clk = 1'b0;
  logic       rst_s = 1'b0;
  logic       rst_d = 1'b0;

  logic [9:0] x_s, y_s, x_d, y_d;
  logic       b_s, hs_s, vs_s, fs_s, b_d, hs_d, vs_d, fs_d;
  logic [7:0] fc_s, fc_d;

  int checks = 0;
  int errors = 0;

  // model state: raster position, running flag, completed frames
  int p_s = 0, p_d = 0, fcm_s = 0, fcm_d = 0;
  bit run_s = 0, run_d = 0;

  // hsync pulse tracker for the 640x480 instance
  int hlow = 0;
  int hstart = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_ACTIVE(SV_A), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
    .SYNC_POL(1'b0)
  ) u_small (
    .vga_clk(clk), .reset_n(rst_s), .DrawX(x_s), .DrawY(y_s), .blank(b_s),
    .hs(hs_s), .vs(vs_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  vga_timing_gen u_dflt (
    .vga_clk(clk), .reset_n(rst_d), .DrawX(x_d), .DrawY(y_d), .blank(b_d),
    .hs(hs_d), .vs(vs_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {x, y, blank, hs, vs, frame_start, frame_count} from raster index.
  function automatic logic [33:0] model_out(int p, bit running, int fc,
                                            int ha, int hf, int hsw, int hb,
                                            int va, int vf, int vsw);
    int ht, x, y;
    bit b, h, v, f;
    ht = ha + hf + hsw + hb;
    if (!running) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'(fc)};
    x = p % ht;
    y = p / ht;
    b = (x < ha) && (y < va);
    h = !((x >= ha + hf) && (x < ha + hf + hsw));
    v = !((y >= va + vf) && (y < va + vf + vsw));
    f = (p == 0);
    return {10'(x), 10'(y), b, h, v, f, 8'(fc)};
  endfunction

  // One clock: advance the models with the reset levels applied at this edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (!rst_s) begin p_s = 0; run_s = 0; fcm_s = 0; end
    else if (!run_s) run_s = 1;
    else begin p_s++; if (p_s == FR_S) begin p_s = 0; fcm_s = (fcm_s + 1) % 256; end end
    if (!rst_d) begin p_d = 0; run_d = 0; fcm_d = 0; end
    else if (!run_d) run_d = 1;
    else begin p_d++; if (p_d == FR_D) begin p_d = 0; fcm_d = (fcm_d + 1) % 256; end end
    #1;
    check("small_out", {x_s, y_s, b_s, hs_s, vs_s, fs_s, fc_s},
          model_out(p_s, run_s, fcm_s, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S));
    check("vga_out", {x_d, y_d, b_d, hs_d, vs_d, fs_d, fc_d},
          model_out(p_d, run_d, fcm_d, 640, 16, 96, 48, 480, 10, 2));
    if (hs_d == 1'b0) begin
      if (hlow == 0) hstart = int'(x_d);
      hlow++;
    end else if (hlow != 0) begin
      check("hs_width", 34'(hlow), 34'(96));
      check("hs_start", 34'(hstart), 34'(656));
      hlow = 0;
    end
    if (errors >= 50) finish_run();
  endtask

  initial begin
    bit mid_done;
    int fs_cnt, inc_cnt, inc_fs;
    logic [7:0] prev_fc;
    mid_done = 0;

    // reset held for five clocks, then release both
    rst_s = 1'b0;
    rst_d = 1'b0;
    repeat (5) tick();
    rst_s = 1'b1;
    rst_d = 1'b1;
    tick();
    check("release_fs", 34'(fs_d), 34'(1));
    tick();
    check("count_start", 34'(x_d), 34'(1));

    // random short resets on the small instance, one mid-line reset on the VGA instance
    for (int i = 0; i < 5000; i++) begin
      rst_s = ($urandom_range(0, 299) != 0);
      rst_d = 1'b1;
      if (!mid_done && x_d == 10'd300 && y_d == 10'd3) begin
        rst_d = 1'b0;
        mid_done = 1;
      end
      tick();
    end
    check("mid_reset_hit", 34'(mid_done), 34'(1));
    rst_d = 1'b1;

    // clean start, then 256 uninterrupted frames so frame_count wraps to 0
    rst_s = 1'b0;
    tick();
    tick();
    rst_s = 1'b1;
    tick();
    fs_cnt  = int'(fs_s);
    inc_cnt = 0;
    inc_fs  = 0;
    prev_fc = fc_s;
    for (int i = 0; i < 256 * FR_S; i++) begin
      tick();
      if (fs_s) fs_cnt++;
      if (fc_s != prev_fc) begin
        inc_cnt++;
        if (fs_s && x_s == 10'd0 && y_s == 10'd0) inc_fs++;
      end
      prev_fc = fc_s;
    end
    check("frame_pulses", 34'(fs_cnt), 34'(257));
    check("fc_increments", 34'(inc_cnt), 34'(256));
    check("fc_inc_at_fs", 34'(inc_fs), 34'(256));
    check("fc_wrapped", 34'(fc_s), 34'(0));
    finish_run();
  end

endmodule
